cla_adder_pipe: RTL and testbench
=================================

# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the team's 8-bit single-cycle CLA slice to WIDTH bits. It processes one BLOCK-bit lookahead slice per pipeline stage and registers the carry between stages. It accepts one operation per cycle through a valid/ready handshake and reports carry-out, signed overflow and zero flags. It sits between the ALU operand muxes and the writeback path wherever a full-width single-cycle adder does not close timing.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per stage by a full carry-lookahead slice (generate g=a&b, propagate p=a|b).
- STAGES, WIDTH/BLOCK, derived; pipeline depth; not overridable.

- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A-B (A + ~B + 1), 0 = A+B+cin.
- cin  input  1  carry-in; ignored when sub=1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR cout.
- zero  output  1  sum == 0.

## Operation
- Accept: a transfer occurs when in_valid && in_ready. Stage 0 captures B' = sub ? ~b : b, c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) computes slice [k*BLOCK +: BLOCK] with a full lookahead carry: c[i+1] = g[i] | p[i]&c[i], flattened per bit. The stage sum bit is (a^B')^c.
- Each stage registers: its completed sum slice, all lower sum slices passed forward, the unconsumed upper operand slices of A and B', the slice carry-out, and a valid bit.
- The last stage also registers cout, ovf (carry into bit WIDTH-1 XOR cout), and zero (full sum == 0).
- Global stall: adv = ~out_valid | out_ready. All stage registers, including valid bits, update only when adv=1. in_ready = adv, combinational.
- Bubbles do not collapse: an empty stage still occupies a slot. Results leave strictly in acceptance order.
- When in_valid=0 and adv=1, a bubble (valid=0) enters stage 0.
- Held output: while out_valid && !out_ready, sum, cout, ovf and zero are held stable and in_ready=0.
- Reset (rst_n low, asynchronous) clears every valid bit and every datapath register. Any in-flight operations are discarded and never appear at the output.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 once rst_n deasserts, because out_valid=0.
- Latency: an operation accepted at rising edge N has out_valid=1 after edge N+STAGES-1. With defaults, a 4-cycle pipeline leaves the result visible in the cycle after the 4th capturing edge.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous out_ready and in_valid with a full pipeline: the output retires and the input is accepted in the same cycle.
- Carry chain critical path is one BLOCK-bit lookahead slice plus the stage-0 operand-inversion mux.

## Test plan
- Carry ripple across all stages: WIDTH=32, BLOCK=8, a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0, out_ready=1 -> after 4 edges sum=0x00000000, cout=1, ovf=0, zero=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0. Then a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
- Backpressure: stream 6 operations (a=i, b=0x10, i=1..6) with out_ready=0 from cycle 2 onward -> in_ready drops once the output is occupied, sum stays 0x00000011 and stable, and no operation is accepted while in_ready=0. Release out_ready -> results 0x11..0x16 appear in order on consecutive cycles, each exactly once.
- Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by STAGES, with matching sums.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 operations in flight -> out_valid=0 and sum=0 immediately, without waiting for a clock edge. After release, in_ready=1 and no stale result is ever emitted.
- Random self-check: 10k random a, b, sub, cin and out_ready, against a reference model (a + (sub ? ~b+1 : b+cin)) including the flags. Run at WIDTH=32/BLOCK=8, WIDTH=16/BLOCK=4 and WIDTH=8/BLOCK=8 (single stage, latency 1).

Source files
------------

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor, one BLOCK-bit slice per stage
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / BLOCK;
  logic adv;
  logic ovf_r, zero_r;
  // carries fully flattened: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y, input logic ci);
    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0] c;
    logic t, pp;
    g = x & y;
    p = x | y;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      t = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & ci);
    end
    return c;
  endfunction
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_st
      localparam int R = WIDTH - k * BLOCK;
      logic [R-1:0] xa, xb;
      logic xc, xv;
      logic [BLOCK:0] c;
      logic [BLOCK-1:0] s;
      logic [(k+1)*BLOCK-1:0] ns, rs;
      logic rc, rv;
      if (k == 0) begin : g_in
        assign xa = a;
        assign xb = sub ? ~b : b;
        assign xc = sub | cin;
        assign xv = in_valid;
        assign ns = s;
      end else begin : g_in
        assign xa = g_st[k-1].g_op.ra;
        assign xb = g_st[k-1].g_op.rb;
        assign xc = g_st[k-1].rc;
        assign xv = g_st[k-1].rv;
        assign ns = {s, g_st[k-1].rs};
      end
      assign c = cla(xa[BLOCK-1:0], xb[BLOCK-1:0], xc);
      assign s = xa[BLOCK-1:0] ^ xb[BLOCK-1:0] ^ c[BLOCK-1:0];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rv <= 1'b0;
          rc <= 1'b0;
          rs <= '0;
        end else if (adv) begin
          rv <= xv;
          rc <= c[BLOCK];
          rs <= ns;
        end
      end
      // only the not-yet-summed upper operand slices travel forward
      if (k < STAGES - 1) begin : g_op
        logic [R-BLOCK-1:0] ra, rb;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ra <= '0;
            rb <= '0;
          end else if (adv) begin
            ra <= xa[R-1:BLOCK];
            rb <= xb[R-1:BLOCK];
          end
        end
      end
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv) begin
      ovf_r <= g_st[STAGES-1].c[BLOCK] ^ g_st[STAGES-1].c[BLOCK-1];
      zero_r <= ~|g_st[STAGES-1].ns;
    end
  end
  assign out_valid = g_st[STAGES-1].rv;
  assign sum = g_st[STAGES-1].rs;
  assign cout = g_st[STAGES-1].rc;
  assign ovf = ovf_r;
  assign zero = zero_r;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed and randomized checks of cla_adder_pipe at 32/8, 16/4 and 8/8
module tb_cla_adder_pipe;
  typedef struct packed { logic [31:0] s; logic c; logic o; logic z; } res_t;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, cin = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;
  logic rdy16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic rdy8, ov8, co8, of8, z8;
  logic [7:0] s8;
  logic rdyx[3], ovx[3], cox[3], ofx[3], zx[3];
  logic [31:0] sx[3];
  int n_vec = 0, n_err = 0;
  res_t q[3][$];

  always #5 clk = ~clk;

  cla_adder_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));
  cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin), .out_valid(ov16), .out_ready(out_ready), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16));
  cla_adder_pipe #(.WIDTH(8), .BLOCK(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin), .out_valid(ov8), .out_ready(out_ready), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8));

  always_comb begin
    rdyx[0] = in_ready; ovx[0] = out_valid; sx[0] = sum; cox[0] = cout; ofx[0] = ovf; zx[0] = zero;
    rdyx[1] = rdy16; ovx[1] = ov16; sx[1] = {16'h0, s16}; cox[1] = co16; ofx[1] = of16; zx[1] = z16;
    rdyx[2] = rdy8; ovx[2] = ov8; sx[2] = {24'h0, s8}; cox[2] = co8; ofx[2] = of8; zx[2] = z8;
  end

  // signed/unsigned integer arithmetic view of the operation
  function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y, input logic s_, input logic ci);
    longint m, ua, ub, sa, sb, r, sr;
    res_t e;
    m = longint'(1) << w;
    ua = longint'(x) & (m - 1);
    ub = longint'(y) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s_) begin
      r = ua - ub; sr = sa - sb; e.c = (ua >= ub);
    end else begin
      r = ua + ub + longint'(ci); sr = sa + sb + longint'(ci); e.c = (r >= m);
    end
    r = ((r % m) + m) % m;
    e.s = 32'(r);
    e.o = (sr < -(m / 2)) || (sr >= m / 2);
    e.z = (r == 0);
    return e;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s_, input logic c_, output int lat);
    @(negedge clk);
    a = x; b = y; sub = s_; cin = c_; in_valid = 1; out_ready = 1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0;
    #1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum got %h want 0", sum); end
    n_vec++; if ({cout, ovf, zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); end
    rst_n = 1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_carry_ripple;
    int lat;
    run_op(32'hFFFF_FFFF, 32'h1, 0, 0, lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL ripple_latency got %0d want 4", lat); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL ripple_sum got %h want 0", sum); end
    n_vec++; if ({cout, ovf, zero} !== 3'b101) begin n_err++; $display("FAIL ripple_flags got %b want 101", {cout, ovf, zero}); end
  endtask

  task automatic test_overflow;
    int lat;
    run_op(32'h7FFF_FFFF, 32'h1, 0, 0, lat);
    n_vec++; if (sum !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_add_sum got %h want 80000000", sum); end
    n_vec++; if ({cout, ovf, zero} !== 3'b010) begin n_err++; $display("FAIL ovf_add_flags got %b want 010", {cout, ovf, zero}); end
    run_op(32'h5, 32'h7, 1, 1, lat);
    n_vec++; if (sum !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_sum got %h want fffffffe", sum); end
    n_vec++; if ({cout, ovf, zero} !== 3'b000) begin n_err++; $display("FAIL sub_flags got %b want 000", {cout, ovf, zero}); end
  endtask

  task automatic test_backpressure;
    int nxt = 1;
    int outs[$], cycs[$];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = (c == 0);
      in_valid = (nxt <= 6); a = 32'(nxt); b = 32'h10; sub = 0; cin = 0;
      #1;
      if (!in_ready) begin
        n_vec++;
        if (out_valid !== 1'b1 || sum !== 32'h11) begin
          n_err++; $display("FAIL bp_hold cycle %0d got valid=%b sum=%h want valid=1 sum=00000011", c, out_valid, sum);
        end
      end
      if (in_valid && in_ready) nxt++;
    end
    n_vec++; if (nxt != 5) begin n_err++; $display("FAIL bp_accepted got %0d want 4", nxt - 1); end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = 1;
      in_valid = (nxt <= 6); a = 32'(nxt);
      #1;
      if (out_valid) begin outs.push_back(int'(sum)); cycs.push_back(c); end
      if (in_valid && in_ready) nxt++;
    end
    in_valid = 0;
    n_vec++; if (outs.size() != 6) begin n_err++; $display("FAIL bp_count got %0d want 6", outs.size()); end
    for (int i = 0; i < outs.size() && i < 6; i++) begin
      n_vec++;
      if (outs[i] != 32'h11 + i || cycs[i] != cycs[0] + i) begin
        n_err++; $display("FAIL bp_order idx %0d got sum=%h cyc=%0d want sum=%h cyc=%0d", i, outs[i], cycs[i], 32'h11 + i, cycs[0] + i);
      end
    end
  endtask

  task automatic test_bubbles;
    bit [3:0] pat = 4'b0101;
    res_t e[4];
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = pat[c]; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        e[c] = model(32, a, b, sub, cin);
      end else in_valid = 0;
      #1;
      n_vec++;
      if (out_valid !== ((c >= 4 && c < 8) ? pat[c-4] : 1'b0)) begin
        n_err++; $display("FAIL bubble_valid cycle %0d got %b", c, out_valid);
      end else if (out_valid) begin
        n_vec++;
        if ({sum, cout, ovf, zero} !== e[c-4]) begin
          n_err++; $display("FAIL bubble_result cycle %0d got %h/%b want %h/%b", c, sum, {cout, ovf, zero}, e[c-4].s, {e[c-4].c, e[c-4].o, e[c-4].z});
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    int stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1; a = 32'(100 + c); b = 32'(c); sub = 0; cin = 0; out_ready = 0;
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    rst_n = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
    n_vec++; if (sum !== 32'h0 || {cout, ovf, zero} !== 3'b000) begin n_err++; $display("FAIL mid_async_data got %h/%b want 0/000", sum, {cout, ovf, zero}); end
    repeat (2) @(negedge clk);
    rst_n = 1; out_ready = 1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    n_vec++; if (stale != 0) begin n_err++; $display("FAIL mid_stale got %0d results want 0", stale); end
  endtask

  task automatic test_random;
    int w[3] = '{32, 16, 8};
    bit held[3] = '{0, 0, 0};
    res_t hv[3], got, e;
    @(negedge clk);
    rst_n = 0; in_valid = 0;
    #1;
    rst_n = 1;
    for (int d = 0; d < 3; d++) q[d].delete();
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        in_valid = ($urandom_range(0, 3) != 0); a = $urandom; b = $urandom;
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1)); out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 0; out_ready = 1;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        got = {sx[d], cox[d], ofx[d], zx[d]};
        if (held[d]) begin
          n_vec++;
          if (ovx[d] !== 1'b1 || got !== hv[d]) begin n_err++; $display("FAIL rnd_hold w%0d cyc %0d got %h want %h", w[d], cyc, got, hv[d]); end
        end
        n_vec++;
        if (rdyx[d] !== (!ovx[d] || out_ready)) begin n_err++; $display("FAIL rnd_in_ready w%0d cyc %0d got %b", w[d], cyc, rdyx[d]); end
        if (ovx[d] && out_ready) begin
          n_vec++;
          if (q[d].size() == 0) begin
            n_err++; $display("FAIL rnd_stale w%0d cyc %0d got %h want none", w[d], cyc, got);
          end else begin
            e = q[d].pop_front();
            if (got !== e) begin n_err++; $display("FAIL rnd_result w%0d cyc %0d got %h want %h", w[d], cyc, got, e); end
          end
        end
        held[d] = ovx[d] && !out_ready;
        hv[d] = got;
        if (in_valid && rdyx[d]) q[d].push_back(model(w[d], a, b, sub, cin));
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_vec++; if (q[d].size() != 0) begin n_err++; $display("FAIL rnd_drain w%0d got %0d left want 0", w[d], q[d].size()); end
    end
  endtask

  task automatic test_latency_all;
    int lat[3] = '{0, 0, 0};
    int want[3] = '{4, 4, 1};
    int e = 1;
    @(negedge clk);
    in_valid = 1; a = $urandom; b = $urandom; sub = 0; cin = 0; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (8) begin
      #1;
      for (int d = 0; d < 3; d++) if (ovx[d] && lat[d] == 0) lat[d] = e;
      @(posedge clk); e++; @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      n_vec++; if (lat[d] != want[d]) begin n_err++; $display("FAIL latency dut%0d got %0d want %0d", d, lat[d], want[d]); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_carry_ripple;
    test_overflow;
    test_backpressure;
    test_bubbles;
    test_reset_midflight;
    test_random;
    test_latency_all;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
